// File: rtl/scarv_cop_arbiter_if.sv
// CPU <-> COP instruction/response channel: the CPU side drives the request and the
// response acknowledge, the COP side drives the request acknowledge and the writeback.
interface scarv_cop_arbiter_if #(
  parameter int ENC_W  = 32,
  parameter int DATA_W = 32
);
  logic              cpu_insn_req;
  logic              cop_insn_ack;
  logic [ENC_W-1:0]  cpu_insn_enc;
  logic [DATA_W-1:0] cpu_rs1;
  logic              cop_wen;
  logic [4:0]        cop_waddr;
  logic [DATA_W-1:0] cop_wdata;
  logic [2:0]        cop_result;
  logic              cop_insn_rsp;
  logic              cpu_insn_ack;

  modport master (
    output cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
    input  cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp
  );

  modport slave (
    input  cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
    output cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp
  );
endinterface

// File: rtl/scarv_cop_arbiter.sv
// Two-requester arbiter in front of one XCrypto COP; one instruction in flight at a time.
// Define SCARV_COP_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module scarv_cop_arbiter #(
  parameter int ENC_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  scarv_cop_arbiter_if.slave  p0,
  scarv_cop_arbiter_if.slave  p1,
  scarv_cop_arbiter_if.master cop,
  output logic                arb_busy,
  output logic                arb_owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RSP} state_t;

  state_t            state;
  logic              owner;
  logic              busy;
  logic              grant;
  logic              own_req;
  logic              own_ack;
  logic [ENC_W-1:0]  own_enc;
  logic [DATA_W-1:0] own_rs1;
  logic              rsp_window;
  logic              issued;
  logic              retire;

  assign own_req = owner ? p1.cpu_insn_req : p0.cpu_insn_req;
  assign own_ack = owner ? p1.cpu_insn_ack : p0.cpu_insn_ack;
  assign own_enc = owner ? p1.cpu_insn_enc : p0.cpu_insn_enc;
  assign own_rs1 = owner ? p1.cpu_rs1      : p0.cpu_rs1;

`ifdef SCARV_COP_ARB_ROUND_ROBIN_EN
  logic last;
  assign grant = (p0.cpu_insn_req && p1.cpu_insn_req) ? ~last : p1.cpu_insn_req;
`else
  assign grant = ~p0.cpu_insn_req;
`endif

  // An ack arriving together with the response counts as issue plus response in one cycle.
  assign issued     = (state == ISSUE) && own_req && cop.cop_insn_ack;
  assign rsp_window = (state == RSP) || issued;
  assign retire     = rsp_window && cop.cop_insn_rsp && own_ack;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!g_resetn) begin
      state <= IDLE;
      owner <= 1'b0;
      busy  <= 1'b0;
`ifdef SCARV_COP_ARB_ROUND_ROBIN_EN
      last  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (p0.cpu_insn_req || p1.cpu_insn_req) begin
            owner <= grant;
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issued) begin
`ifdef SCARV_COP_ARB_ROUND_ROBIN_EN
            last <= owner;
`endif
            if (retire) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RSP;
            end
          end else if (!own_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RSP: begin
          if (retire) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cop.cpu_insn_req = 1'b0;
    cop.cpu_insn_enc = '0;
    cop.cpu_rs1      = '0;
    cop.cpu_insn_ack = 1'b0;
    p0.cop_insn_ack  = 1'b0;
    p0.cop_wen       = 1'b0;
    p0.cop_waddr     = '0;
    p0.cop_wdata     = '0;
    p0.cop_result    = '0;
    p0.cop_insn_rsp  = 1'b0;
    p1.cop_insn_ack  = 1'b0;
    p1.cop_wen       = 1'b0;
    p1.cop_waddr     = '0;
    p1.cop_wdata     = '0;
    p1.cop_result    = '0;
    p1.cop_insn_rsp  = 1'b0;

    if (state == ISSUE) begin
      cop.cpu_insn_req = own_req;
      cop.cpu_insn_enc = own_enc;
      cop.cpu_rs1      = own_rs1;
      if (owner) p1.cop_insn_ack = cop.cop_insn_ack;
      else       p0.cop_insn_ack = cop.cop_insn_ack;
    end

    // The response is steered only to the owner; the other port stays quiet.
    if (rsp_window) begin
      cop.cpu_insn_ack = own_ack;
      if (owner) begin
        p1.cop_wen      = cop.cop_wen;
        p1.cop_waddr    = cop.cop_waddr;
        p1.cop_wdata    = cop.cop_wdata;
        p1.cop_result   = cop.cop_result;
        p1.cop_insn_rsp = cop.cop_insn_rsp;
      end else begin
        p0.cop_wen      = cop.cop_wen;
        p0.cop_waddr    = cop.cop_waddr;
        p0.cop_wdata    = cop.cop_wdata;
        p0.cop_result   = cop.cop_result;
        p0.cop_insn_rsp = cop.cop_insn_rsp;
      end
    end
  end

  assign arb_busy  = busy;
  assign arb_owner = owner;

endmodule

// File: doc/scarv_cop_arbiter.md
Name: scarv_cop_arbiter

Overview:
Two-port arbiter sharing one XCrypto co-processor (COP) between two CPU-side instruction interfaces, e.g. two PicoRV32 cores, each behind its own PCPI-to-COP converter.
- Only one instruction is in flight at the COP at a time.
- It is routed from a granted requester, and the COP response is steered back to that requester only.
- The block sits between the converters and the COP.

Parameters:
- ENC_W, 32, instruction encoding width.
- DATA_W, 32, rs1 and write-data width.

Ports:
Each pN_ line below covers both p0_ and p1_.
- g_clk  in  1  clock.
- g_resetn  in  1  asynchronous active-low reset.
- pN_cpu_insn_req  in  1  requester N instruction request.
- pN_cop_insn_ack  out  1  request accepted by COP.
- pN_cpu_insn_enc  in  ENC_W  requester N encoding.
- pN_cpu_rs1  in  DATA_W  requester N rs1.
- pN_cop_wen  out  1  writeback enable.
- pN_cop_waddr  out  5  writeback address.
- pN_cop_wdata  out  DATA_W  writeback data.
- pN_cop_result  out  3  execution result.
- pN_cop_insn_rsp  out  1  response valid.
- pN_cpu_insn_ack  in  1  requester N accepts response.
- cpu_insn_req  out  1  request to COP.
- cop_insn_ack  in  1  COP accepts request.
- cpu_insn_enc  out  ENC_W  encoding to COP.
- cpu_rs1  out  DATA_W  rs1 to COP.
- cop_wen  in  1  COP writeback enable.
- cop_waddr  in  5  COP writeback address.
- cop_wdata  in  DATA_W  COP write data.
- cop_result  in  3  COP result.
- cop_insn_rsp  in  1  COP response valid.
- cpu_insn_ack  out  1  response acknowledge to COP.
- arb_busy  out  1  state != IDLE.
- arb_owner  out  1  current or last granted port.

Behaviour:
- Reset (asynchronous, g_resetn=0):
  - state=IDLE, owner=0, last=1 (so port 0 wins the first tie).
  - All outputs 0.
  - Reset mid-instruction abandons the instruction with no response; the COP is reset by the same g_resetn.
- FSM states: IDLE, ISSUE, RSP.
- IDLE:
  - When any pN_cpu_insn_req=1, register owner using the priority rule and go to ISSUE.
  - One-cycle arbitration bubble: the COP sees the request no earlier than the cycle after the requester raised it.
- ISSUE:
  - cpu_insn_req = owner req; cpu_insn_enc and cpu_rs1 = owner enc and rs1 (combinational mux).
  - pOwner_cop_insn_ack = cop_insn_ack.
  - Requesters hold enc and rs1 stable until ack.
  - cop_insn_ack=1: go to RSP; last <= owner.
  - Owner drops req before ack: abort to IDLE, nothing issued, last unchanged.
- RSP:
  - All five response signals are forwarded to the owner only; cpu_insn_ack = pOwner_cpu_insn_ack.
  - cop_insn_rsp && owner ack: go to IDLE.
  - Response without ack: stay in RSP; the COP holds the response.
- Same-cycle ack and rsp in ISSUE: treat as issue plus response in that cycle.
  - Forward the response in that cycle.
  - If the owner also acks, go straight to IDLE; otherwise go to RSP.
- Non-owner port outputs are always 0: ack, rsp, wen, waddr, wdata, result.
- In IDLE, cpu_insn_req=0 and enc/rs1=0.
- A requester whose request arrives while the other port holds the COP waits in IDLE-blocked state with no ack. No queue depth beyond one pending request per port.
- Response data is passed through unmodified. result code 3'b010 is not interpreted here.
- arb_busy is registered with the state. arb_owner = owner register.

Optional Feature:
- Macro: SCARV_COP_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. On simultaneous requests in IDLE, grant the port != last. A single requester always wins.
- Undefined: fixed priority. Port 0 wins any tie, and the last register is unused and optimisable.

Test Plan:
- Single request: p0 req with enc=0x0000002B, rs1=0x12345678; COP acks 2 cycles after issue; rsp with wen=1, waddr=5, wdata=0xCAFEF00D, result=0.
  - Required: COP sees req on cycle+1 with those values.
  - p0 sees ack, then rsp with identical fields; p1 outputs stay 0; arb_busy falls after p0 ack.
- Simultaneous p0 and p1 requests, three instructions each, with round-robin defined.
  - Required grant order 0,1,0,1,0,1.
  - Without the macro, order is 0,0,0,1,1,1.
- Response back-pressure: p1 holds cpu_insn_ack=0 for 4 cycles during rsp.
  - Required: state stays RSP, cpu_insn_ack=0 to the COP, p0 request blocked; IDLE follows the cycle after p1 acks.
- Abort: p0 req for 2 cycles in ISSUE with no COP ack, then p0 drops req.
  - Required: return to IDLE; a pending p1 request is granted next and last is unchanged.
- Same-cycle ack and rsp with owner ack high.
  - Required: response forwarded that cycle and the FSM in IDLE the next cycle.
- Reset during RSP: assert g_resetn=0 asynchronously.
  - Required: all outputs 0 immediately; after release the first tie grants port 0.
